// File: rtl/song_player.sv
// Note-table playback engine: walks the song ROM, times each note, optional gap, loop/pause/stop.
// Optional feature: define SONG_PLAYER_TEMPO_EN to add the tempo[1:0] duration-scaling input.
module song_player #(
  parameter int ADDR_W     = 9,
  parameter int SONG_W     = 4,
  parameter int NOTE_W     = 4,
  parameter int DUR_W      = 32,
  parameter int GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop_en,
  input  logic [SONG_W-1:0] song_sel,
`ifdef SONG_PLAYER_TEMPO_EN
  input  logic [1:0]        tempo,
`endif
  output logic [ADDR_W-1:0] rom_addr,
  output logic [SONG_W-1:0] rom_song,
  input  logic [NOTE_W-1:0] rom_note,
  input  logic [DUR_W-1:0]  rom_dur,
  output logic [NOTE_W-1:0] note,
  output logic              note_on,
  output logic              playing,
  output logic              done
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

  state_t            state;
  logic [DUR_W-1:0]  dur_cnt;
  logic [DUR_W-1:0]  eff_dur;
  logic [GW-1:0]     gap_cnt;
  logic              last_addr;
  logic              fin;
  logic              eos;

`ifdef SONG_PLAYER_TEMPO_EN
  logic [DUR_W-1:0] shifted;
  // a nonzero entry never scales down to a terminator
  assign shifted = rom_dur >> tempo;
  assign eff_dur = (shifted == '0) ? DUR_W'(1) : shifted;
`else
  assign eff_dur = rom_dur;
`endif

  assign last_addr = &rom_addr;
  // fin: current entry fully played (note + gap); eos: song terminates this cycle
  assign fin = !pause && ((state == PLAY && dur_cnt == '0 && GAP_CYCLES == 0) ||
                          (state == GAP && gap_cnt == '0));
  assign eos = !pause && ((state == LOAD && rom_dur == '0) || (fin && last_addr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rom_addr <= '0;
      rom_song <= '0;
      note     <= '0;
      note_on  <= 1'b0;
      playing  <= 1'b0;
      done     <= 1'b0;
      dur_cnt  <= '0;
      gap_cnt  <= '0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state    <= IDLE;
        rom_addr <= '0;
        note     <= '0;
        note_on  <= 1'b0;
        playing  <= 1'b0;
        dur_cnt  <= '0;
        gap_cnt  <= '0;
      end else if (start) begin
        state    <= LOAD;
        rom_song <= song_sel;
        rom_addr <= '0;
        note     <= '0;
        note_on  <= 1'b0;
        playing  <= 1'b1;
      end else if (eos) begin
        note_on <= 1'b0;
        if (loop_en) begin
          rom_addr <= '0;
          state    <= LOAD;
        end else begin
          state    <= IDLE;
          rom_addr <= '0;
          note     <= '0;
          playing  <= 1'b0;
          done     <= 1'b1;
        end
      end else if (fin) begin
        note_on  <= 1'b0;
        rom_addr <= rom_addr + 1'b1;
        state    <= LOAD;
      end else if (!pause) begin
        case (state)
          LOAD: begin
            note    <= rom_note;
            dur_cnt <= eff_dur - DUR_W'(1);
            note_on <= (rom_note != '0);
            state   <= PLAY;
          end
          PLAY: begin
            // dur_cnt == 0 only lands here when a gap follows
            if (dur_cnt == '0) begin
              note    <= '0;
              note_on <= 1'b0;
              gap_cnt <= GAP_LD;
              state   <= GAP;
            end else begin
              dur_cnt <= dur_cnt - DUR_W'(1);
              note_on <= (note != '0);
            end
          end
          GAP:     gap_cnt <= gap_cnt - GW'(1);
          default: ;
        endcase
      end else begin
        note_on <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_song_player.sv
// Randomized bench for song_player: two instances (no gap, 2-cycle gap) against a timeline model.
module tb_song_player;
  localparam int AW = 3, SW = 4, NW = 4, DW = 32, HOLD = -1;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start = 0, stop = 0, pause = 0, loop_en = 0;
  logic [SW-1:0] song_sel = '0;
  logic [1:0] tempo = '0;

  logic [AW-1:0] ra [2];
  logic [SW-1:0] rs [2];
  logic [NW-1:0] rnote [2], nt [2];
  logic [DW-1:0] rdur [2];
  logic non [2], ply [2], dn_o [2];

  logic [NW-1:0] rn [16][8];
  logic [DW-1:0] rd [16][8];

  assign rnote[0] = rn[rs[0]][ra[0]];
  assign rdur[0]  = rd[rs[0]][ra[0]];
  assign rnote[1] = rn[rs[1]][ra[1]];
  assign rdur[1]  = rd[rs[1]][ra[1]];

  song_player #(.ADDR_W(AW), .SONG_W(SW), .NOTE_W(NW), .DUR_W(DW), .GAP_CYCLES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause), .loop_en(loop_en),
    .song_sel(song_sel),
`ifdef SONG_PLAYER_TEMPO_EN
    .tempo(tempo),
`endif
    .rom_addr(ra[0]), .rom_song(rs[0]), .rom_note(rnote[0]), .rom_dur(rdur[0]),
    .note(nt[0]), .note_on(non[0]), .playing(ply[0]), .done(dn_o[0]));

  song_player #(.ADDR_W(AW), .SONG_W(SW), .NOTE_W(NW), .DUR_W(DW), .GAP_CYCLES(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause), .loop_en(loop_en),
    .song_sel(song_sel),
`ifdef SONG_PLAYER_TEMPO_EN
    .tempo(tempo),
`endif
    .rom_addr(ra[1]), .rom_song(rs[1]), .rom_note(rnote[1]), .rom_dur(rdur[1]),
    .note(nt[1]), .note_on(non[1]), .playing(ply[1]), .done(dn_o[1]));

  // Model: a song is expanded into a list of per-cycle frames; each clock either
  // advances one frame, repeats it (pause), jumps to frame 0 (loop) or leaves.
  typedef struct {
    int addr;
    int note;
    bit on;
    bit endf;
  } frame_t;

  frame_t tl [2][64];
  int ci [2] = '{-1, -1};
  int song [2] = '{0, 0};
  int enote [2] = '{0, 0};
  bit pz [2] = '{0, 0};
  bit edn [2] = '{0, 0};

  int nchk = 0, nerr = 0, cycn = 0;
  int done_at [2];
  int done_cnt [2];

  task automatic chk(input string tag, input int got, input int exp);
    nchk++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic build(input int g, input int s);
    int n, gap, d, e;
    n = 0;
    gap = (g == 0) ? 0 : 2;
    for (int k = 0; k < 8; k++) begin
      d = int'(rd[s][k]);
      tl[g][n] = '{k, HOLD, 1'b0, d == 0};
      n++;
      if (d == 0) break;
      e = d >> tempo;
      if (e == 0) e = 1;
      for (int j = 0; j < e; j++) begin
        tl[g][n] = '{k, int'(rn[s][k]), rn[s][k] != 0, 1'b0};
        n++;
      end
      for (int j = 0; j < gap; j++) begin
        tl[g][n] = '{k, 0, 1'b0, 1'b0};
        n++;
      end
      if (k == 7) tl[g][n-1].endf = 1'b1;
    end
  endtask

  task automatic step();
    for (int g = 0; g < 2; g++) begin
      edn[g] = 1'b0;
      if (stop) begin
        ci[g] = -1; pz[g] = 1'b0; enote[g] = 0;
      end else if (start) begin
        song[g] = int'(song_sel);
        build(g, song[g]);
        ci[g] = 0; pz[g] = 1'b0; enote[g] = 0;
      end else if (ci[g] < 0) begin
        pz[g] = 1'b0;
      end else if (pause) begin
        pz[g] = 1'b1;
      end else if (tl[g][ci[g]].endf) begin
        pz[g] = 1'b0;
        if (loop_en) ci[g] = 0;
        else begin
          ci[g] = -1; edn[g] = 1'b1; enote[g] = 0;
        end
      end else begin
        pz[g] = 1'b0;
        ci[g]++;
      end
      if (ci[g] >= 0 && tl[g][ci[g]].note != HOLD) enote[g] = tl[g][ci[g]].note;
    end
  endtask

  task automatic mreset();
    for (int g = 0; g < 2; g++) begin
      ci[g] = -1; pz[g] = 1'b0; edn[g] = 1'b0; song[g] = 0; enote[g] = 0;
    end
  endtask

  task automatic cyc();
    int ea, eon;
    string p;
    @(posedge clk);
    step();
    cycn++;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      p = (g == 0) ? "g0" : "g2";
      ea  = (ci[g] < 0) ? 0 : tl[g][ci[g]].addr;
      eon = (ci[g] >= 0 && tl[g][ci[g]].on && !pz[g]) ? 1 : 0;
      chk({p, ".rom_addr"}, int'(ra[g]), ea);
      chk({p, ".rom_song"}, int'(rs[g]), song[g]);
      chk({p, ".note"}, int'(nt[g]), enote[g]);
      chk({p, ".note_on"}, int'(non[g]), eon);
      chk({p, ".playing"}, int'(ply[g]), (ci[g] >= 0) ? 1 : 0);
      chk({p, ".done"}, int'(dn_o[g]), int'(edn[g]));
      if (dn_o[g] && done_at[g] < 0) done_at[g] = cycn;
      if (dn_o[g]) done_cnt[g]++;
    end
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic go(input int s);
    song_sel = SW'(s);
    start = 1'b1;
    cycn = 0;
    done_at = '{-1, -1};
    done_cnt = '{0, 0};
    cyc();
    start = 1'b0;
  endtask

  task automatic halt();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  task automatic zero_chk(input string tag);
    for (int g = 0; g < 2; g++) begin
      chk({tag, ".addr"}, int'(ra[g]), 0);
      chk({tag, ".song"}, int'(rs[g]), 0);
      chk({tag, ".note"}, int'(nt[g]), 0);
      chk({tag, ".note_on"}, int'(non[g]), 0);
      chk({tag, ".playing"}, int'(ply[g]), 0);
      chk({tag, ".done"}, int'(dn_o[g]), 0);
    end
  endtask

  initial begin
    int len;
    for (int s = 0; s < 16; s++)
      for (int k = 0; k < 8; k++) begin
        rn[s][k] = '0;
        rd[s][k] = '0;
      end
    rn[0][0] = 4'd1; rd[0][0] = 32'd3;
    rn[0][1] = 4'd5; rd[0][1] = 32'd2;
    rn[15][0] = 4'd3; rd[15][0] = 32'd12;
    rn[15][1] = 4'd4; rd[15][1] = 32'd1;
    for (int s = 1; s < 15; s++) begin
      len = (s >= 13) ? 8 : int'($urandom_range(0, 8));
      for (int k = 0; k < 8; k++) begin
        rn[s][k] = NW'($urandom_range(0, 9));
        rd[s][k] = (k < len) ? DW'($urandom_range(1, 4)) : '0;
      end
    end
    done_at = '{-1, -1};
    done_cnt = '{0, 0};

    repeat (2) @(negedge clk);
    zero_chk("reset");
    rst_n = 1'b1;
    run(3);

    // basic playback: done 9 cycles after the start edge, 4 more with the gap
    go(0);
    run(20);
    chk("basic.done_at.g0", done_at[0], 9);
    chk("basic.done_at.g2", done_at[1], 13);

    // 5 paused cycles mid-note delay everything by 5
    go(0);
    run(2);
    pause = 1'b1;
    run(5);
    pause = 1'b0;
    run(20);
    chk("pause.done_at.g0", done_at[0], 14);
    chk("pause.done_at.g2", done_at[1], 18);

    go(0);
    run(2);
    halt();
    chk("stop.playing", int'(ply[0]), 0);
    chk("stop.note", int'(nt[0]), 0);
    chk("stop.done", int'(dn_o[0]), 0);

    go(0);
    run(3);
    song_sel = 4'd1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("restart.song", int'(rs[0]), 1);
    chk("restart.addr", int'(ra[0]), 0);
    halt();

    go(0);
    run(2);
    #1 rst_n = 1'b0;
    #1 zero_chk("async_rst");
    mreset();
    #1 rst_n = 1'b1;
    run(2);

    // loop three passes, then release loop_en and expect one done
    loop_en = 1'b1;
    go(0);
    run(26);
    chk("loop.nodone.g0", done_cnt[0], 0);
    chk("loop.nodone.g2", done_cnt[1], 0);
    loop_en = 1'b0;
    run(30);
    chk("loop.done.g0", done_cnt[0], 1);
    chk("loop.done.g2", done_cnt[1], 1);

`ifdef SONG_PLAYER_TEMPO_EN
    tempo = 2'd2;
    go(15);
    run(30);
    chk("tempo2.done_at.g0", done_at[0], 8);
    tempo = 2'd3;
    go(15);
    run(30);
    chk("tempo3.done_at.g0", done_at[0], 6);
    tempo = 2'd0;
`endif

    for (int i = 0; i < 3000; i++) begin
      stop = ($urandom_range(0, 79) == 0);
      if (stop) start = 1'b0;
      else if (!ply[0] && !ply[1]) start = ($urandom_range(0, 3) == 0);
      else start = ($urandom_range(0, 59) == 0);
      song_sel = SW'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) pause = ~pause;
      if ($urandom_range(0, 29) == 0) loop_en = ~loop_en;
`ifdef SONG_PLAYER_TEMPO_EN
      if (stop) tempo = 2'($urandom_range(0, 3));
`endif
      cyc();
    end
    start = 1'b0;
    pause = 1'b0;
    halt();

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/song_player.md
# song_player

Sequential playback engine for the note-table ROMs. Latches a song selection, walks the ROM address space entry by entry, holds each note for its table duration in clock cycles, inserts an optional articulation gap between notes, and detects end-of-song from a zero-duration entry. Supports loop, pause and stop. Sits between the user-control logic and the tone generator; the note ROM is an external combinational lookup.

## Interface
- `ADDR_W`, 9: ROM address width.
- `SONG_W`, 4: song-select width.
- `NOTE_W`, 4: note code width; code 0 is a rest.
- `DUR_W`, 32: duration width, in clock cycles.
- `GAP_CYCLES`, 0: silent cycles inserted after each note; 0 disables the gap.

- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: level-sampled; begins playback of `song_sel` from address 0.
- `stop` in 1: aborts playback and returns to idle.
- `pause` in 1: while high, playback freezes.
- `loop_en` in 1: sampled at end-of-song; if 1, restart at address 0.
- `song_sel` in SONG_W: song to play; latched on accepted `start`.
- `rom_addr` out ADDR_W: registered ROM address.
- `rom_song` out SONG_W: latched song index driven to the ROM.
- `rom_note` in NOTE_W: combinational ROM note for (`rom_song`, `rom_addr`).
- `rom_dur` in DUR_W: combinational ROM duration; 0 marks end-of-song.
- `note` out NOTE_W: current note to the tone generator; 0 means silence.
- `note_on` out 1: high in PLAY when `note` ≠ 0 and not paused.
- `playing` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse on non-looping end-of-song.

## Operation
- States: IDLE, LOAD, PLAY, GAP.
- **IDLE**
  - On `start`: latch `song_sel` into `rom_song`, set `rom_addr` to 0, and go to LOAD.
- **LOAD** (one cycle): sample `rom_note` and `rom_dur`.
  - If `rom_dur` is 0, or `rom_addr` equals 2^ADDR_W−1 with a nonzero duration (the entry is played first), end-of-song applies.
  - Otherwise: `note` ← `rom_note`, `dur_cnt` ← `rom_dur` − 1, go to PLAY.
- **PLAY**
  - `dur_cnt` decrements each unpaused cycle.
  - When `dur_cnt` reaches 0: if `GAP_CYCLES` > 0, set `note` to 0, load the gap counter and go to GAP. Otherwise increment `rom_addr` and go to LOAD.
- **GAP**: counts `GAP_CYCLES` cycles with `note` = 0, then increments `rom_addr` and goes to LOAD.
- **End-of-song**
  - With `loop_en` = 1: `rom_addr` ← 0 and go to LOAD. `done` does not pulse.
  - With `loop_en` = 0: pulse `done`, set `note` to 0 and go to IDLE.
  - The last address, 2^ADDR_W−1, is never wrapped silently.
- **Pause**: freezes all counters and `rom_addr`. `note` is held internally, but `note_on` is forced to 0. Pause has no effect in IDLE.
- **Priority**: `stop` > `start` > `pause`.
  - `stop` from any state → IDLE next cycle, `note` = 0, no `done`.
  - `start` while `playing` restarts with the new `song_sel` at address 0. This includes `start` while paused.
- **Rest entries**: note 0 with nonzero duration are timed normally, with `note_on` = 0.

## Timing
- Reset values: `rom_addr` = 0, `rom_song` = 0, `note` = 0, `note_on` = 0, `playing` = 0, `done` = 0, state = IDLE, all counters = 0.
- `start` sampled at edge N:
  - LOAD during cycle N+1 (`rom_addr` = 0 valid).
  - `note` valid from edge N+2.
- Each entry occupies exactly `rom_dur` + `GAP_CYCLES` + 1 cycles (the +1 is LOAD). Pause cycles are added to that.
- `done` asserts for exactly one cycle: the cycle after the LOAD that saw the terminating entry. `playing` falls on the same edge.
- All outputs are registered. `rom_note` and `rom_dur` must settle within one cycle of a `rom_addr` change.
- Reset asserted mid-playback clears all outputs immediately (asynchronously).

## Configuration
- **`SONG_PLAYER_TEMPO_EN` defined**:
  - Adds input `tempo` [1:0].
  - Effective duration = `rom_dur` >> `tempo`, with a minimum of 1 when `rom_dur` ≠ 0.
  - `tempo` is sampled in each LOAD.
  - A nonzero `rom_dur` that shifts to 0 is clamped to 1 and never treated as end-of-song.
- **Undefined**: no `tempo` port; durations are used unscaled.

## Test plan
- **Basic playback**:
  - Setup: ROM song 0 = {note 1 dur 3, note 5 dur 2, dur 0}, `GAP_CYCLES` = 0; `start` at cycle 10.
  - Required: `note` = 1 for cycles 12–14, LOAD at cycle 15, `note` = 5 for cycles 16–17, `done` pulse at cycle 19, then IDLE.
- **Gap**:
  - Setup: same ROM, `GAP_CYCLES` = 2.
  - Required: `note` = 0 for 2 cycles after each note; `done` is 4 cycles later than in the basic case.
- **Loop**:
  - Setup: `loop_en` = 1.
  - Required: after the dur-0 entry, `rom_addr` returns to 0 with no `done`, and the note sequence 1, 5 repeats 3 times. Deasserting `loop_en` → `done` after the current pass.
- **Pause and stop**:
  - Pause: pause for 5 cycles mid-note. Required: `note_on` = 0 and the note lasts 5 cycles longer.
  - Stop: `stop` mid-note. Required: IDLE next cycle, `note` = 0, `done` = 0.
- **Restart and reset**:
  - Restart: `start` with `song_sel` = 1 while playing song 0. Required: `rom_song` = 1 and `rom_addr` = 0 next cycle.
  - Reset: `rst_n` low mid-note. Required: all outputs 0 immediately.
- **Tempo** (`SONG_PLAYER_TEMPO_EN`):
  - `tempo` = 2 with `rom_dur` = 12 → note lasts 3 cycles.
  - `rom_dur` = 1 with `tempo` = 3 → note lasts 1 cycle, not treated as end-of-song.
